// File: rtl/iob_cache_line_fill_pkg.sv
// -----------------------------------------------------------------------------
// iob_cache_line_fill_pkg
// Shared definitions for the cache back-end read (line fill) channel:
//   - fill_state_t : two-state fill FSM encoding (IDLE=1'd0, FILL=1'd1), the
//                    same encoding the write channel uses
//   - line2be_w()  : number of index bits needed to walk one cache line in
//                    back-end words
//   - max1()       : clamps a width to at least one bit
// No ports (package).
// -----------------------------------------------------------------------------
package iob_cache_line_fill_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'd0,
      ST_FILL = 1'd1
   } fill_state_t;

   // FE words per line is 2^word_offset_w; each BE word packs
   // be_data_w/fe_data_w FE words, so fewer BE beats are needed.
   function automatic int line2be_w(input int word_offset_w,
                                    input int be_data_w,
                                    input int fe_data_w);
      return word_offset_w - $clog2(be_data_w / fe_data_w);
   endfunction

   function automatic int max1(input int v);
      return (v > 1) ? v : 1;
   endfunction

endpackage

// File: rtl/iob_cache_fill_counter.sv
// -----------------------------------------------------------------------------
// iob_cache_fill_counter
// Beat sequencing for one line fill: keeps the BE-word index within the line
// and decides when the final beat is being transferred.
// Optional feature macro: IOB_CACHE_FILL_WRAP_EN
//   defined   : critical-word-first; index starts at start_i and wraps modulo
//               BEATS, a separate beat counter decides completion
//   undefined : index starts at 0 and doubles as the beat counter
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   load_i         : start a new fill (loads start index, clears beat count)
//   start_i        : start index for critical-word-first
//   inc_i          : beat acknowledged, advance
//   idx_o          : current BE-word index within the line
//   idx_nxt_o      : index that follows idx_o (wrapping)
//   last_o         : current beat is the final beat of the line
// -----------------------------------------------------------------------------
module iob_cache_fill_counter
   import iob_cache_line_fill_pkg::*;
#(
   parameter int LINE2BE_W = 2,
   parameter int IDX_W     = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [IDX_W-1:0] start_i,
   input  logic             inc_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [IDX_W-1:0] idx_nxt_o,
   output logic             last_o
);

   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   generate
      if (LINE2BE_W == 0) begin : g_single_beat
         // Whole line is one BE word: nothing to count.
         logic unused_ctl_s;
         assign unused_ctl_s = ^{clk_i, reset_i, load_i, start_i, inc_i};
         assign idx_o        = '0;
         assign idx_nxt_o    = '0;
         assign last_o       = 1'b1;
      end else begin : g_multi_beat
`ifdef IOB_CACHE_FILL_WRAP_EN
         logic [IDX_W-1:0] idx_q, idx_d;
         logic [IDX_W-1:0] beat_q, beat_d;

         // Next index / beat count: load on new fill, step on ack.
         // IDX_W == LINE2BE_W here, so natural overflow is the modulo-BEATS wrap.
         always_comb begin
            idx_d  = idx_q;
            beat_d = beat_q;
            if (load_i) begin
               idx_d  = start_i;
               beat_d = '0;
            end else if (inc_i) begin
               idx_d  = idx_q + IDX_ONE;
               beat_d = beat_q + IDX_ONE;
            end else begin
               idx_d  = idx_q;
               beat_d = beat_q;
            end
         end

         // Index and beat count registers.
         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
               idx_q  <= '0;
               beat_q <= '0;
            end else begin
               idx_q  <= idx_d;
               beat_q <= beat_d;
            end
         end

         assign idx_o     = idx_q;
         assign idx_nxt_o = idx_q + IDX_ONE;
         // Completion follows the beat count, not the (wrapping) index.
         assign last_o    = (beat_q == '1);
`else
         logic [IDX_W-1:0] idx_q, idx_d;
         logic             unused_start_s;

         // Linear fill always starts from word 0.
         assign unused_start_s = ^start_i;

         // Next index: clear on new fill, step on ack.
         always_comb begin
            idx_d = idx_q;
            if (load_i) begin
               idx_d = '0;
            end else if (inc_i) begin
               idx_d = idx_q + IDX_ONE;
            end else begin
               idx_d = idx_q;
            end
         end

         // Index register (also the beat count).
         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
               idx_q <= '0;
            end else begin
               idx_q <= idx_d;
            end
         end

         assign idx_o     = idx_q;
         assign idx_nxt_o = idx_q + IDX_ONE;
         assign last_o    = (idx_q == '1);
`endif
      end
   endgenerate

endmodule

// File: rtl/iob_cache_line_fill.sv
// -----------------------------------------------------------------------------
// iob_cache_line_fill
// Back-end read channel of the cache. On a miss it fetches a full cache line
// from back-end memory one BE word at a time (native valid/ack interface) and
// streams every returned word into the cache data memory with its word index.
// Optional feature macro: IOB_CACHE_FILL_WRAP_EN (critical-word-first order).
// Ports:
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   replace_valid_i  : line-fill request from the control unit
//   replace_addr_i   : miss address, BE-word granularity
//   replace_o        : fill in progress, cache must stall
//   read_valid_o     : write strobe into cache data memory (ack cycle)
//   read_addr_o      : BE-word index within the line
//   read_data_o      : returned data (always be_rdata_i)
//   be_addr_o        : back-end byte address, BE-word aligned
//   be_valid_o       : back-end request
//   be_ack_i         : back-end acknowledge, data valid same cycle
//   be_rdata_i       : back-end read data
// -----------------------------------------------------------------------------
module iob_cache_line_fill
   import iob_cache_line_fill_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int FE_DATA_W     = 32,
   parameter int BE_ADDR_W     = 32,
   parameter int BE_DATA_W     = 32,
   parameter int WORD_OFFSET_W = 2,
   localparam int BE_NBYTES_W  = $clog2(BE_DATA_W / 8),
   localparam int LINE2BE_W    = line2be_w(WORD_OFFSET_W, BE_DATA_W, FE_DATA_W),
   localparam int IDX_W        = max1(LINE2BE_W)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          replace_valid_i,
   input  logic [ADDR_W-BE_NBYTES_W-1:0] replace_addr_i,
   output logic                          replace_o,
   output logic                          read_valid_o,
   output logic [IDX_W-1:0]              read_addr_o,
   output logic [BE_DATA_W-1:0]          read_data_o,
   output logic [BE_ADDR_W-1:0]          be_addr_o,
   output logic                          be_valid_o,
   input  logic                          be_ack_i,
   input  logic [BE_DATA_W-1:0]          be_rdata_i
);

   localparam int RADDR_W = ADDR_W - BE_NBYTES_W;
   localparam int LINE_W  = RADDR_W - LINE2BE_W;

   fill_state_t       state_q, state_d;
   logic [LINE_W-1:0] line_q, line_d;

   logic              load_s;
   logic              inc_s;
   logic [IDX_W-1:0]  start_s;
   logic [IDX_W-1:0]  idx_s;
   logic [IDX_W-1:0]  idx_nxt_s;
   logic              last_s;
   logic [IDX_W-1:0]  be_idx_s;
   logic [ADDR_W-1:0] addr_full_s;

   // With a single-beat line the counter ignores start_s.
   assign start_s = replace_addr_i[IDX_W-1:0];

   iob_cache_fill_counter #(
      .LINE2BE_W (LINE2BE_W),
      .IDX_W     (IDX_W)
   ) u_fill_counter (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (load_s),
      .start_i   (start_s),
      .inc_i     (inc_s),
      .idx_o     (idx_s),
      .idx_nxt_o (idx_nxt_s),
      .last_o    (last_s)
   );

   // FSM next state, line-address latch and back-end/cache-side strobes.
   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      load_s       = 1'b0;
      inc_s        = 1'b0;
      replace_o    = 1'b0;
      be_valid_o   = 1'b0;
      read_valid_o = 1'b0;
      be_idx_s     = idx_s;
      case (state_q)
         ST_IDLE: begin
            // Stall the cache already in the request cycle.
            replace_o = replace_valid_i;
            if (replace_valid_i) begin
               load_s  = 1'b1;
               line_d  = replace_addr_i[RADDR_W-1:LINE2BE_W];
               state_d = ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            replace_o  = 1'b1;
            be_valid_o = ~(be_ack_i & last_s);
            if (be_ack_i) begin
               read_valid_o = 1'b1;
               inc_s        = 1'b1;
               // Present the next word's address now so the next request
               // follows back-to-back.
               be_idx_s     = idx_nxt_s;
               state_d      = last_s ? ST_IDLE : ST_FILL;
            end else begin
               state_d = ST_FILL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Byte address of the requested BE word; zero outside a fill.
   always_comb begin
      addr_full_s = (ADDR_W'(line_q) << (LINE2BE_W + BE_NBYTES_W)) |
                    (ADDR_W'(be_idx_s) << BE_NBYTES_W);
      if (state_q == ST_FILL) begin
         be_addr_o = BE_ADDR_W'(addr_full_s);
      end else begin
         be_addr_o = '0;
      end
   end

   assign read_addr_o = idx_s;
   assign read_data_o = be_rdata_i;

   // State and latched line address.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: tb/tb_iob_cache_line_fill.sv
module tb_iob_cache_line_fill;

   logic         clk;
   logic         reset_i;

   // Main instance: 32-bit BE words, 4 beats per line.
   logic         rv;
   logic [29:0]  ra;
   logic         ack;
   logic [31:0]  rdata;
   logic         replace_o, read_valid_o, be_valid_o;
   logic [1:0]   read_addr_o;
   logic [31:0]  read_data_o, be_addr_o;

   // Single-beat instance: 128-bit BE words, whole line in one beat.
   logic         rv1;
   logic [27:0]  ra1;
   logic         ack1;
   logic [127:0] rdata1;
   logic         replace1_o, read_valid1_o, be_valid1_o;
   logic [0:0]   read_addr1_o;
   logic [127:0] read_data1_o;
   logic [31:0]  be_addr1_o;

   int n_assert = 0;
   int n_fail   = 0;
   int n_rdv    = 0;

   // Reference model of one line fill: the list of beats still owed.
   bit          m_fill;
   int          m_k;
   int          m_start;
   logic [27:0] m_line;

   iob_cache_line_fill u_dut (
      .clk_i(clk), .reset_i(reset_i),
      .replace_valid_i(rv), .replace_addr_i(ra),
      .replace_o(replace_o), .read_valid_o(read_valid_o),
      .read_addr_o(read_addr_o), .read_data_o(read_data_o),
      .be_addr_o(be_addr_o), .be_valid_o(be_valid_o),
      .be_ack_i(ack), .be_rdata_i(rdata)
   );

   iob_cache_line_fill #(.BE_DATA_W(128)) u_dut1 (
      .clk_i(clk), .reset_i(reset_i),
      .replace_valid_i(rv1), .replace_addr_i(ra1),
      .replace_o(replace1_o), .read_valid_o(read_valid1_o),
      .read_addr_o(read_addr1_o), .read_data_o(read_data1_o),
      .be_addr_o(be_addr1_o), .be_valid_o(be_valid1_o),
      .be_ack_i(ack1), .be_rdata_i(rdata1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] baddr(input int idx);
      return ({4'd0, m_line} << 4) + (32'(idx % 4) << 2);
   endfunction

   // One clock cycle on the main instance: drive, check, advance the model.
   task automatic step(input logic rv_v, input logic [29:0] ra_v,
                       input logic ack_v, input logic [31:0] rd_v);
      int cur;
      bit last;
      logic e_rep, e_bv, e_rdv;
      @(negedge clk);
      rv = rv_v; ra = ra_v; ack = ack_v; rdata = rd_v;
      #1;
      if (read_valid_o === 1'b1) n_rdv++;
      if (!m_fill) begin
         e_rep = rv_v; e_bv = 1'b0; e_rdv = 1'b0;
         chk("rep", 128'(replace_o), 128'(e_rep));
         chk("bvalid", 128'(be_valid_o), 128'(e_bv));
         chk("rvalid", 128'(read_valid_o), 128'(e_rdv));
         if (rv_v) begin
            m_fill = 1'b1;
            m_k    = 0;
            m_line = ra_v[29:2];
`ifdef IOB_CACHE_FILL_WRAP_EN
            m_start = int'(ra_v[1:0]);
`else
            m_start = 0;
`endif
         end
      end else begin
         cur  = (m_start + m_k) % 4;
         last = (m_k == 3);
         e_bv = !(ack_v && last);
         chk("rep_fill", 128'(replace_o), 128'(1'b1));
         chk("bvalid", 128'(be_valid_o), 128'(e_bv));
         chk("rvalid", 128'(read_valid_o), 128'(ack_v));
         if (e_bv) chk("be_addr", 128'(be_addr_o), 128'(ack_v ? baddr(cur + 1) : baddr(cur)));
         if (ack_v) begin
            chk("read_addr", 128'(read_addr_o), 128'(cur));
            chk("read_data", 128'(read_data_o), 128'(rd_v));
            m_k++;
            if (m_k == 4) m_fill = 1'b0;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rv = 1'b0; ack = 1'b0;
      reset_i = 1'b1;
      #1;
      m_fill = 1'b0;
      chk("rst_rep", 128'(replace_o), 128'(1'b0));
      chk("rst_bvalid", 128'(be_valid_o), 128'(1'b0));
      chk("rst_rvalid", 128'(read_valid_o), 128'(1'b0));
      @(negedge clk);
      reset_i = 1'b0;
   endtask

   initial begin
      int rv_cnt;
      logic [29:0] req;
      reset_i = 1'b1;
      rv = 1'b0; ra = '0; ack = 1'b0; rdata = '0;
      rv1 = 1'b0; ra1 = '0; ack1 = 1'b0; rdata1 = '0;
      m_fill = 1'b0; m_k = 0; m_start = 0; m_line = '0;

      // Reset state.
      @(negedge clk); #1;
      chk("reset_rep", 128'(replace_o), 128'(1'b0));
      chk("reset_bvalid", 128'(be_valid_o), 128'(1'b0));
      chk("reset_rvalid", 128'(read_valid_o), 128'(1'b0));
      chk("reset_be_addr", 128'(be_addr_o), 128'(32'h0));
      chk("reset_read_addr", 128'(read_addr_o), 128'(2'd0));
      chk("reset1_rep", 128'(replace1_o), 128'(1'b0));
      chk("reset1_bvalid", 128'(be_valid1_o), 128'(1'b0));
      @(negedge clk);
      reset_i = 1'b0;

      // Back-to-back acks, line at 0x100.
      n_rdv = 0;
      step(1'b1, 30'h100, 1'b0, $urandom);
      for (int i = 0; i < 4; i++) step(1'b0, 30'h0, 1'b1, $urandom);
      step(1'b0, 30'h0, 1'b0, $urandom);
      chk("pulses_b2b", 128'(n_rdv), 128'(4));

      // Three wait cycles per beat.
      n_rdv = 0;
      step(1'b1, 30'h2A5, 1'b0, $urandom);
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 3; w++) step(1'b0, 30'h0, 1'b0, $urandom);
         step(1'b0, 30'h0, 1'b1, $urandom);
      end
      step(1'b0, 30'h0, 1'b0, $urandom);
      chk("pulses_wait", 128'(n_rdv), 128'(4));

      // Request at 0x102 (critical-word-first order when wrap is enabled).
      step(1'b1, 30'h102, 1'b0, $urandom);
      for (int i = 0; i < 4; i++) step(1'b0, 30'h0, 1'b1, $urandom);
      step(1'b0, 30'h0, 1'b0, $urandom);

      // Stray ack in IDLE, request re-asserted with other addresses in FILL.
      n_rdv = 0;
      step(1'b0, 30'h0, 1'b1, $urandom);
      step(1'b0, 30'h0, 1'b1, $urandom);
      chk("stray_ack", 128'(n_rdv), 128'(0));
      step(1'b1, 30'h3C1, 1'b0, $urandom);
      step(1'b1, 30'h0F3, 1'b0, $urandom);
      step(1'b1, 30'h0F3, 1'b1, $urandom);
      step(1'b0, 30'h123, 1'b1, $urandom);
      step(1'b1, 30'h3FF, 1'b0, $urandom);
      step(1'b1, 30'h3FF, 1'b1, $urandom);
      step(1'b1, 30'h001, 1'b1, $urandom);
      step(1'b0, 30'h0, 1'b0, $urandom);

      // Reset after the second ack, then a clean fill.
      step(1'b1, 30'h155, 1'b0, $urandom);
      step(1'b0, 30'h0, 1'b1, $urandom);
      step(1'b0, 30'h0, 1'b1, $urandom);
      pulse_reset();
      step(1'b0, 30'h0, 1'b0, $urandom);
      step(1'b1, 30'h204, 1'b0, $urandom);
      for (int i = 0; i < 4; i++) step(1'b0, 30'h0, 1'b1, $urandom);
      step(1'b0, 30'h0, 1'b0, $urandom);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         req = 30'($urandom);
         step(($urandom_range(0, 3) == 0), req, ($urandom_range(0, 1) == 1), $urandom);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 30'h0, 1'b1, $urandom);

      // Single-beat line (128-bit BE words).
      @(negedge clk);
      rv1 = 1'b1; ra1 = 28'h1234567; ack1 = 1'b0;
      #1;
      chk("sb_rep_req", 128'(replace1_o), 128'(1'b1));
      chk("sb_bvalid_req", 128'(be_valid1_o), 128'(1'b0));
      @(negedge clk);
      rv1 = 1'b0; ra1 = 28'h0;
      rdata1 = {$urandom, $urandom, $urandom, $urandom};
      ack1 = 1'b1;
      #1;
      chk("sb_rep_ack", 128'(replace1_o), 128'(1'b1));
      chk("sb_bvalid_ack", 128'(be_valid1_o), 128'(1'b0));
      chk("sb_rvalid", 128'(read_valid1_o), 128'(1'b1));
      chk("sb_read_addr", 128'(read_addr1_o), 128'(1'b0));
      chk("sb_read_data", read_data1_o, rdata1);
      @(negedge clk);
      ack1 = 1'b0;
      #1;
      chk("sb_rep_done", 128'(replace1_o), 128'(1'b0));
      chk("sb_rvalid_done", 128'(read_valid1_o), 128'(1'b0));
      // Single beat with a wait cycle to observe the address.
      @(negedge clk);
      rv1 = 1'b1; ra1 = 28'hABCDEF1;
      @(negedge clk);
      rv1 = 1'b0;
      #1;
      rv_cnt = 0;
      chk("sb_bvalid_wait", 128'(be_valid1_o), 128'(1'b1));
      chk("sb_be_addr", 128'(be_addr1_o), 128'(32'hABCDEF10));
      @(negedge clk);
      ack1 = 1'b1;
      #1;
      if (read_valid1_o === 1'b1) rv_cnt++;
      @(negedge clk);
      ack1 = 1'b0;
      #1;
      if (read_valid1_o === 1'b1) rv_cnt++;
      chk("sb_pulses", 128'(rv_cnt), 128'(1));
      chk("sb_rep_idle", 128'(replace1_o), 128'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
